// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART byte-stream command decoder driving single read/write cycles on the 16-bit memory bus.
module uart_bus_bridge #(
  parameter int AW = 15,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_dat,
  input  logic          i_rx_valid,
  output logic [7:0]    o_tx_dat,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_dat,
  input  logic [15:0]   i_dat,
  output logic          o_we,
  output logic          o_cyc,
  output logic [1:0]    o_stb,
  input  logic          i_ack,
  output logic          o_busy,
  output logic          o_overrun
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ARG, BUS, TX1, TX2} state_t;
  state_t state, state_n;
  logic op_w, ok, overrun, ack_ok, tmo, last, known;
  logic [2:0] rem;
  logic [AW-1:0] addr;
  logic [15:0] data;
  logic [7:0] rd_lo, tx_dat;
  logic [CW-1:0] cnt;
  always_comb begin
    known = i_rx_dat == 8'h57 || i_rx_dat == 8'h52;
    ack_ok = state == BUS && i_ack;
    tmo = state == BUS && !i_ack && cnt == CW'(TIMEOUT - 1);
    last = state == ARG && i_rx_valid && rem == 3'd1;
    state_n = state == IDLE && i_rx_valid ? (known ? ARG : TX1)
            : last ? BUS
            : ack_ok || tmo ? TX1
            : state == TX1 && i_tx_ready ? (ok ? TX2 : IDLE)
            : state == TX2 && i_tx_ready ? IDLE
            : state;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      op_w <= 1'b0;
      ok <= 1'b0;
      overrun <= 1'b0;
      rem <= '0;
      addr <= '0;
      data <= '0;
      rd_lo <= '0;
      tx_dat <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      overrun <= i_rx_valid && (state == BUS || state == TX1 || state == TX2);
      cnt <= state == BUS ? cnt + 1'b1 : '0;
      if (state == IDLE) ok <= 1'b0;
      if (state == IDLE && i_rx_valid) begin
        op_w <= i_rx_dat == 8'h57;
        rem <= i_rx_dat == 8'h57 ? 3'd4 : 3'd2;
        tx_dat <= 8'h3F;
      end
      // write commands send address then data; reads send address only
      if (state == ARG && i_rx_valid) begin
        rem <= rem - 3'd1;
        if (!op_w || rem > 3'd2) addr <= AW'({addr, i_rx_dat});
        else data <= {data[7:0], i_rx_dat};
      end
      if (ack_ok) begin
        ok <= !op_w;
        tx_dat <= op_w ? 8'h4B : i_dat[15:8];
        rd_lo <= i_dat[7:0];
      end
      if (tmo) tx_dat <= 8'h45;
      if (state == TX1 && i_tx_ready && ok) tx_dat <= rd_lo;
    end
  end
  assign o_cyc = state == BUS;
  assign o_stb = {2{o_cyc}};
  assign o_we = o_cyc && op_w;
  assign o_addr = addr;
  assign o_dat = data;
  assign o_tx_dat = tx_dat;
  assign o_tx_valid = state == TX1 || state == TX2;
  assign o_busy = state != IDLE;
  assign o_overrun = overrun;
endmodule
